// File: rtl/mw_writeback_stage.sv
// MEM/WB pipeline register and writeback logic.
// Drives the register file write port, aligns/extends load data from the
// synchronous data memory (holding it across stalls), provides the WB->ID
// bypass, and counts retired instructions.
module mw_writeback_stage #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MW_Stall,
  input  logic             MW_Flush,
  input  logic             EM_Valid,
  input  logic             EM_RegWrite,
  input  logic             EM_MemToReg,
  input  logic [2:0]       EM_LoadType,
  input  logic [AW-1:0]    EM_WBAddr,
  input  logic [DW-1:0]    EM_ALUOut,
  input  logic [DW-1:0]    DM_RData,
  input  logic [AW-1:0]    ID_Rs,
  input  logic [AW-1:0]    ID_Rt,
  output logic             MW_RegWrite,
  output logic [AW-1:0]    MW_WBAddr,
  output logic [DW-1:0]    MW_WBData,
  output logic             ID_RsFwd,
  output logic             ID_RtFwd,
  output logic [CNT_W-1:0] MW_InstRet
);

  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  // stage state
  logic             vld_q;
  logic             regwrite_q;
  logic             memtoreg_q;
  logic [2:0]       loadtype_q;
  logic [AW-1:0]    wbaddr_q;
  logic [DW-1:0]    aluout_q;
  logic             hold_vld_q;
  logic [DW-1:0]    hold_data_q;
  logic [CNT_W-1:0] instret_q;

  // Stage register: reset > flush > stall (latch load word once) > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      loadtype_q  <= 3'd0;
      wbaddr_q    <= '0;
      aluout_q    <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else if (MW_Flush) begin
      vld_q      <= 1'b0;
      hold_vld_q <= 1'b0;
    end else if (MW_Stall) begin
      // memory only presents the word for one cycle, so grab it on the
      // first stalled cycle and keep using the copy afterwards
      if (vld_q && memtoreg_q && !hold_vld_q) begin
        hold_data_q <= DM_RData;
        hold_vld_q  <= 1'b1;
      end
    end else begin
      vld_q      <= EM_Valid;
      regwrite_q <= EM_RegWrite;
      memtoreg_q <= EM_MemToReg;
      loadtype_q <= EM_LoadType;
      wbaddr_q   <= EM_WBAddr;
      aluout_q   <= EM_ALUOut;
      hold_vld_q <= 1'b0;
    end
  end

  // Retire counter: an instruction retires when it leaves a valid, unstalled stage
  always_ff @(posedge clk) begin
    if (rst)
      instret_q <= '0;
    else if (vld_q && !MW_Stall)
      instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  logic [DW-1:0] ld_word;
  logic [15:0]   ld_half;
  logic [7:0]    ld_byte;
  logic [DW-1:0] ld_aligned;

  // Load alignment and sign/zero extension (little-endian)
  always_comb begin
    ld_word = hold_vld_q ? hold_data_q : DM_RData;
    ld_half = aluout_q[1] ? ld_word[31:16] : ld_word[15:0];
    case (aluout_q[1:0])
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    case (loadtype_q)
      LD_LH:   ld_aligned = {{(DW-16){ld_half[15]}}, ld_half};
      LD_LHU:  ld_aligned = {{(DW-16){1'b0}}, ld_half};
      LD_LB:   ld_aligned = {{(DW-8){ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_aligned = {{(DW-8){1'b0}}, ld_byte};
      default: ld_aligned = ld_word;
    endcase
  end

  // Write port and WB->ID bypass; r0 writes never reach the register file
  always_comb begin
    MW_RegWrite = vld_q & regwrite_q & (wbaddr_q != '0);
    MW_WBAddr   = wbaddr_q;
    MW_WBData   = memtoreg_q ? ld_aligned : aluout_q;
    ID_RsFwd    = MW_RegWrite & (ID_Rs == wbaddr_q);
    ID_RtFwd    = MW_RegWrite & (ID_Rt == wbaddr_q);
    MW_InstRet  = instret_q;
  end

endmodule

// File: tb/tb_mw_writeback_stage.sv
// Scoreboard bench for mw_writeback_stage: directed cases followed by random
// traffic, checked against a transaction-level model of the stage.
module tb_mw_writeback_stage;

  logic        clk = 1'b0;
  logic        rst, MW_Stall, MW_Flush, EM_Valid, EM_RegWrite, EM_MemToReg;
  logic [2:0]  EM_LoadType;
  logic [4:0]  EM_WBAddr, ID_Rs, ID_Rt;
  logic [31:0] EM_ALUOut, DM_RData;
  logic        MW_RegWrite, ID_RsFwd, ID_RtFwd;
  logic [4:0]  MW_WBAddr;
  logic [31:0] MW_WBData, MW_InstRet;
  // narrow-counter copy to exercise wrap-around in reasonable time
  logic        rw3, rsf3, rtf3;
  logic [4:0]  addr3;
  logic [31:0] data3;
  logic [2:0]  cnt3;

  always #5 clk = ~clk;

  mw_writeback_stage dut (
    .clk(clk), .rst(rst), .MW_Stall(MW_Stall), .MW_Flush(MW_Flush),
    .EM_Valid(EM_Valid), .EM_RegWrite(EM_RegWrite), .EM_MemToReg(EM_MemToReg),
    .EM_LoadType(EM_LoadType), .EM_WBAddr(EM_WBAddr), .EM_ALUOut(EM_ALUOut),
    .DM_RData(DM_RData), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .MW_RegWrite(MW_RegWrite), .MW_WBAddr(MW_WBAddr), .MW_WBData(MW_WBData),
    .ID_RsFwd(ID_RsFwd), .ID_RtFwd(ID_RtFwd), .MW_InstRet(MW_InstRet));

  mw_writeback_stage #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .MW_Stall(MW_Stall), .MW_Flush(MW_Flush),
    .EM_Valid(EM_Valid), .EM_RegWrite(EM_RegWrite), .EM_MemToReg(EM_MemToReg),
    .EM_LoadType(EM_LoadType), .EM_WBAddr(EM_WBAddr), .EM_ALUOut(EM_ALUOut),
    .DM_RData(DM_RData), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .MW_RegWrite(rw3), .MW_WBAddr(addr3), .MW_WBData(data3),
    .ID_RsFwd(rsf3), .ID_RtFwd(rtf3), .MW_InstRet(cnt3));

  typedef struct {
    logic rst, flush, stall, valid, rw, m2r;
    logic [2:0] lt;
    logic [4:0] addr, rs, rt;
    logic [31:0] alu, dm;
  } stim_t;

  typedef struct {
    logic rw, rs_fwd, rt_fwd, known;
    logic [4:0] addr;
    logic [31:0] data, cnt;
  } exp_t;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  stim_t s;

  // abstract model of the instruction sitting in the stage
  bit          m_valid = 0, m_rw = 0, m_m2r = 0, m_have = 0, m_known = 1;
  int          m_lt = 0;
  logic [4:0]  m_addr = 0;
  logic [31:0] m_alu = 0, m_word = 0, m_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // load result from the word, type and byte offset using plain shifts
  function automatic logic [31:0] load_val(logic [31:0] w, int lt, int off);
    logic [31:0] v;
    case (lt)
      1, 2: begin
        v = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
        if (lt == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      3, 4: begin
        v = (w >> (8 * off)) & 32'h0000_00FF;
        if (lt == 3 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // apply one cycle of stimulus, predict this cycle's outputs, then advance the model
  task automatic step();
    exp_t e;
    @(posedge clk); #1;
    rst = s.rst; MW_Flush = s.flush; MW_Stall = s.stall;
    EM_Valid = s.valid; EM_RegWrite = s.rw; EM_MemToReg = s.m2r;
    EM_LoadType = s.lt; EM_WBAddr = s.addr; EM_ALUOut = s.alu;
    DM_RData = s.dm; ID_Rs = s.rs; ID_Rt = s.rt;
    e.rw     = m_valid && m_rw && (m_addr != 0);
    e.addr   = m_addr;
    e.data   = m_m2r ? load_val(m_have ? m_word : s.dm, m_lt, int'(m_alu % 4)) : m_alu;
    e.rs_fwd = e.rw && (s.rs == m_addr);
    e.rt_fwd = e.rw && (s.rt == m_addr);
    e.cnt    = m_cnt;
    e.known  = m_known;
    sb.push_back(e);
    if (s.rst) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_lt = 0; m_addr = 0; m_alu = 0;
      m_have = 0; m_known = 1; m_cnt = 0;
    end else begin
      if (m_valid && !s.stall) m_cnt = m_cnt + 1;
      if (s.flush) begin
        m_valid = 0; m_have = 0; m_known = 0;
      end else if (s.stall) begin
        if (m_valid && m_m2r && !m_have) begin m_have = 1; m_word = s.dm; end
      end else begin
        m_valid = s.valid; m_rw = s.rw; m_m2r = s.m2r; m_lt = int'(s.lt);
        m_addr = s.addr; m_alu = s.alu; m_have = 0; m_known = 1;
      end
    end
  endtask

  task automatic bubble();
    s.valid = 0; s.rw = 0; s.m2r = 0; s.lt = 0; s.addr = 0; s.alu = 0;
    s.stall = 0; s.flush = 0; s.rst = 0;
  endtask

  // monitor: compare every presented cycle against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("regwrite", 32'(MW_RegWrite), 32'(e.rw));
        chk("rs_fwd", 32'(ID_RsFwd), 32'(e.rs_fwd));
        chk("rt_fwd", 32'(ID_RtFwd), 32'(e.rt_fwd));
        chk("instret", MW_InstRet, e.cnt);
        chk("instret3", 32'(cnt3), e.cnt & 32'h7);
        chk("regwrite3", 32'(rw3), 32'(e.rw));
        if (e.known) begin
          chk("wbaddr", 32'(MW_WBAddr), 32'(e.addr));
          chk("wbdata", MW_WBData, e.data);
          chk("wbdata3", data3, e.data);
        end
      end
    end
  end

  logic [2:0]  ld_lt  [6] = '{3'd3, 3'd4, 3'd4, 3'd1, 3'd2, 3'd0};
  logic [1:0]  ld_off [6] = '{2'd3, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
  logic [31:0] ld_exp [6] = '{32'hFFFF_FF80, 32'h0000_007F, 32'h0000_00FF,
                              32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    logic [31:0] c0;
    s = '{default: '0};
    s.rst = 1;
    rst = 1; MW_Flush = 0; MW_Stall = 0; EM_Valid = 0; EM_RegWrite = 0;
    EM_MemToReg = 0; EM_LoadType = 0; EM_WBAddr = 0; EM_ALUOut = 0;
    DM_RData = 0; ID_Rs = 0; ID_Rt = 0;
    repeat (2) @(posedge clk);

    // reset held with busy EM inputs
    s.valid = 1; s.rw = 1; s.m2r = 1; s.addr = 9; s.alu = 32'hFFFF; s.dm = 32'h1234;
    s.rs = 9; s.rt = 9;
    step(); step();
    #1;
    chk("rst_regwrite", 32'(MW_RegWrite), 0);
    chk("rst_wbdata", MW_WBData, 0);
    chk("rst_instret", MW_InstRet, 0);

    // ALU writeback and bypass
    bubble(); s.valid = 1; s.rw = 1; s.addr = 8; s.alu = 32'h1234_5678;
    step();
    bubble(); s.rs = 8; s.rt = 3;
    step(); #1;
    chk("alu_regwrite", 32'(MW_RegWrite), 1);
    chk("alu_wbaddr", 32'(MW_WBAddr), 8);
    chk("alu_wbdata", MW_WBData, 32'h1234_5678);
    chk("alu_rsfwd", 32'(ID_RsFwd), 1);
    chk("alu_rtfwd", 32'(ID_RtFwd), 0);

    // load alignment, back to back
    s.dm = 32'h80FF_7F01;
    for (int i = 0; i <= 6; i++) begin
      bubble();
      if (i < 6) begin
        s.valid = 1; s.rw = 1; s.m2r = 1; s.lt = ld_lt[i];
        s.addr = 5'(i + 1); s.alu = 32'h1000 + 32'(ld_off[i]);
      end
      step();
      if (i > 0) begin #1; chk("load_align", MW_WBData, ld_exp[i-1]); end
    end

    // stalled LW keeps the first-cycle word and retires once
    bubble(); s.valid = 1; s.rw = 1; s.m2r = 1; s.addr = 3; s.alu = 32'h2000;
    step();
    bubble(); s.stall = 1; s.dm = 32'hCAFE_F00D;
    c0 = m_cnt;
    step(); #1; chk("stall_data0", MW_WBData, 32'hCAFE_F00D);
    s.dm = 32'hDEAD_BEEF;
    step(); #1; chk("stall_data1", MW_WBData, 32'hCAFE_F00D);
    step(); #1; chk("stall_data2", MW_WBData, 32'hCAFE_F00D);
    chk("stall_cnt", MW_InstRet, c0);
    s.stall = 0;
    step(); #1; chk("release_data", MW_WBData, 32'hCAFE_F00D);
    step(); #1; chk("release_cnt", MW_InstRet, c0 + 1);

    // r0 write suppressed
    bubble(); s.valid = 1; s.rw = 1; s.addr = 0; s.alu = 5; s.rs = 0; s.rt = 0;
    step();
    bubble();
    step(); #1;
    chk("r0_regwrite", 32'(MW_RegWrite), 0);
    chk("r0_rsfwd", 32'(ID_RsFwd), 0);

    // flush during stall clears the stage without counting
    bubble(); s.valid = 1; s.rw = 1; s.addr = 4; s.alu = 77;
    step();
    bubble(); s.stall = 1; s.flush = 1;
    c0 = m_cnt;
    step();
    bubble();
    step(); #1;
    chk("flush_regwrite", 32'(MW_RegWrite), 0);
    chk("flush_cnt", MW_InstRet, c0);

    // random traffic (narrow counter wraps many times)
    for (int n = 0; n < 400; n++) begin
      s.rst   = ($urandom_range(0, 59) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.stall = ($urandom_range(0, 3) == 0);
      s.valid = ($urandom_range(0, 4) != 0);
      s.rw    = ($urandom_range(0, 3) != 0);
      s.m2r   = $urandom_range(0, 1) == 1;
      s.lt    = 3'($urandom_range(0, 7));
      s.addr  = 5'($urandom_range(0, 7));
      s.rs    = 5'($urandom_range(0, 7));
      s.rt    = 5'($urandom_range(0, 7));
      s.alu   = $urandom;
      s.dm    = $urandom;
      step();
    end

    bubble();
    step();
    @(negedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
